// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_AW    = $clog2(DEF_DEPTH);

    // Address width for a given register count (at least one bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_pending_table.sv
// Per-register pending-write bits with flush > issue-set > write-back-clear priority.
module rf_pending_table
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_enable,
    input  logic [AW-1:0]    issue_addr,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic             flush,
    input  logic [AW-1:0]    read_addr1,
    input  logic [AW-1:0]    read_addr2,
    output logic             busy1,
    output logic             busy2,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    // Next-state per bit; a younger issue wins over a same-address write-back.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                pending_next[i] = 1'b0;
            end else if (issue_enable && (issue_addr == AW'(i))) begin
                pending_next[i] = 1'b1;
            end else if (write_enable && (write_addr == AW'(i))) begin
                pending_next[i] = 1'b0;
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Lookups reflect pre-edge state; same-cycle write-back is deliberately not bypassed.
    assign busy_vec = pending;
    assign busy1    = pending[read_addr1];
    assign busy2    = pending[read_addr2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file: two registered read ports with write bypass, one write port,
// plus a pending-write scoreboard for RAW hazard detection at decode.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_enable,
    input  logic [AW-1:0]    read_addr1,
    input  logic [AW-1:0]    read_addr2,
    output logic [N-1:0]     read_data1,
    output logic [N-1:0]     read_data2,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic [N-1:0]     write_data,
    input  logic             issue_enable,
    input  logic [AW-1:0]    issue_addr,
    input  logic             flush,
    output logic             busy1,
    output logic             busy2,
    output logic [DEPTH-1:0] busy_vec
);

    logic [N-1:0] regs [DEPTH];
    logic         hit1;
    logic         hit2;

    assign hit1 = write_enable && (write_addr == read_addr1);
    assign hit2 = write_enable && (write_addr == read_addr2);

    // Architectural storage, written at the edge on write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[write_addr] <= write_data;
        end
    end

    // Registered read ports; same-cycle write data is forwarded instead of the stale entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data1 <= '0;
            read_data2 <= '0;
        end else if (read_enable) begin
            read_data1 <= hit1 ? write_data : regs[read_addr1];
            read_data2 <= hit2 ? write_data : regs[read_addr2];
        end
    end

    rf_pending_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_pending (
        .clk          (clk),
        .rst          (rst),
        .issue_enable (issue_enable),
        .issue_addr   (issue_addr),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .flush        (flush),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .busy1        (busy1),
        .busy2        (busy2),
        .busy_vec     (busy_vec)
    );

endmodule
